// File: rtl/keypad_matrix_emu.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_matrix_emu
//  Description : 4x4 membrane keypad emulator for the column-scanning keypad
//                reader. The reader drives active-low column strobes on
//                scan_code. A key requested over key_valid/key_ready answers
//                on read_code like a passive switch. The key is held for
//                HOLD_SCANS activations of its column, then released. A gap
//                of GAP_SCANS activations must then pass before the next
//                request is accepted. A watchdog aborts HOLD/GAP when the
//                column stops being scanned.
//                Optional macro KEYPAD_BOUNCE_EN adds a contact-bounce
//                pattern at press and at release.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_emu #(
    parameter int HOLD_SCANS  = 4,
    parameter int GAP_SCANS   = 2,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] scan_code,
    output logic [3:0] read_code,
    output logic       pressed,
    output logic       done,
    output logic       timeout
);

    localparam logic [2:0]  S_IDLE = 3'd0;
    localparam logic [2:0]  S_HOLD = 3'd1;
    localparam logic [2:0]  S_GAP  = 3'd2;
`ifdef KEYPAD_BOUNCE_EN
    localparam logic [2:0]  S_BIN  = 3'd3;   // bounce after press
    localparam logic [2:0]  S_BOUT = 3'd4;   // bounce before gap
    // six 8-cycle phases
    localparam logic [5:0]  C_BOUNCE_LAST = 6'd47;
`endif

    localparam logic [7:0]  C_HOLD_CNT = 8'(HOLD_SCANS);
    localparam logic [7:0]  C_GAP_CNT  = 8'(GAP_SCANS);
    localparam logic [23:0] C_WD_LAST  = 24'(TIMEOUT_CYC - 1);

    // Key map: column select of each hex key
    function automatic logic [1:0] key_col(input logic [3:0] k);
        case (k)
            4'h1, 4'h4, 4'h7, 4'hE: return 2'd0;
            4'h2, 4'h5, 4'h8, 4'h0: return 2'd1;
            4'h3, 4'h6, 4'h9, 4'hF: return 2'd2;
            default:                return 2'd3;   // A, B, C, D
        endcase
    endfunction

    // Key map: row return of each hex key
    function automatic logic [1:0] key_row(input logic [3:0] k);
        case (k)
            4'h1, 4'h2, 4'h3, 4'hA: return 2'd0;
            4'h4, 4'h5, 4'h6, 4'hB: return 2'd1;
            4'h7, 4'h8, 4'h9, 4'hC: return 2'd2;
            default:                return 2'd3;   // E, 0, F, D
        endcase
    endfunction

    logic [2:0]  state_q, state_d;
    logic [3:0]  key_q, key_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] wd_q, wd_d;
    logic        samp_q;
    logic        pressed_q, pressed_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
`ifdef KEYPAD_BOUNCE_EN
    logic [5:0]  bcnt_q, bcnt_d;
`endif

    logic [1:0]  col_w;
    logic [1:0]  row_w;
    logic [1:0]  col_nxt_w;
    logic        col_now_w;
    logic        act_w;
    logic        rise_w;

    assign col_w     = key_col(key_q);
    assign row_w     = key_row(key_q);
    assign col_nxt_w = key_col(key_d);
    assign col_now_w = scan_code[col_w];
    // Activation = falling edge of the key's column between two samples
    assign act_w     = samp_q & ~col_now_w;
    assign rise_w    = ~samp_q & col_now_w;

    assign key_ready = (state_q == S_IDLE);
    assign pressed   = pressed_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    // Passive switch: row pulled low only while its column is strobed
    assign read_code = (pressed_q && !col_now_w) ? ~(4'b0001 << row_w) : 4'b1111;

    // State, counters and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            key_q     <= 4'h0;
            cnt_q     <= 8'd0;
            wd_q      <= 24'd0;
            samp_q    <= 1'b1;
            pressed_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
            bcnt_q    <= 6'd0;
`endif
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            // Sample the column that will be selected next cycle, so a newly
            // accepted key never sees a false edge from the old column.
            samp_q    <= scan_code[col_nxt_w];
            pressed_q <= pressed_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
`ifdef KEYPAD_BOUNCE_EN
            bcnt_q    <= bcnt_d;
`endif
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
`ifdef KEYPAD_BOUNCE_EN
        bcnt_d  = bcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    key_d = key_code;
                    cnt_d = 8'd0;
                    wd_d  = 24'd0;
`ifdef KEYPAD_BOUNCE_EN
                    state_d = S_BIN;
                    bcnt_d  = 6'd0;
`else
                    state_d = S_HOLD;
`endif
                end
            end
            S_HOLD: begin
                if (act_w) begin
                    // Saturating count; activation beats watchdog expiry
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    wd_d  = 24'd0;
                end else if (rise_w && (cnt_q == C_HOLD_CNT)) begin
                    // Release only once the final strobe has ended
                    cnt_d = 8'd0;
`ifdef KEYPAD_BOUNCE_EN
                    state_d = S_BOUT;
                    bcnt_d  = 6'd0;
`else
                    state_d = S_GAP;
`endif
                end else if (wd_q == C_WD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    // Cannot wrap: expiry fires before the top value
                    wd_d = wd_q + 24'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == C_GAP_CNT) begin
                    state_d = S_IDLE;
                end else if (act_w) begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    wd_d  = 24'd0;
                end else if (wd_q == C_WD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 24'd1;
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            S_BIN: begin
                if (bcnt_q == C_BOUNCE_LAST) begin
                    state_d = S_HOLD;
                    cnt_d   = 8'd0;
                    wd_d    = 24'd0;
                end else begin
                    bcnt_d = bcnt_q + 6'd1;
                end
            end
            S_BOUT: begin
                if (bcnt_q == C_BOUNCE_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = 8'd0;
                    wd_d    = 24'd0;
                end else begin
                    bcnt_d = bcnt_q + 6'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, registered alongside the state
    always_comb begin
        pressed_d = 1'b0;
        case (state_d)
            S_HOLD:  pressed_d = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
            // Phase parity: in-bounce starts closed, out-bounce starts open
            S_BIN:   pressed_d = ~bcnt_d[3];
            S_BOUT:  pressed_d = bcnt_d[3];
`endif
            default: pressed_d = 1'b0;
        endcase
        done_d    = (state_q == S_GAP) && (cnt_q == C_GAP_CNT);
        // Any other exit from HOLD/GAP to IDLE is a watchdog abort
        timeout_d = ((state_q == S_HOLD) || (state_q == S_GAP)) &&
                    (state_d == S_IDLE) && !done_d;
    end

endmodule
`default_nettype wire
